// File: rtl/de_morgan_checker_if.sv
// de_morgan_checker_if: start/result handshake plus gate drive and sense lines
interface de_morgan_checker_if;
  logic start;
  logic a_out;
  logic b_out;
  logic c_in;
  logic busy;
  logic done;
  logic pass;
  logic [2:0] err_count;
  logic [3:0] fail_vec;
  modport master (
    output start, c_in,
    input  a_out, b_out, busy, done, pass, err_count, fail_vec
  );
  modport slave (
    input  start, c_in,
    output a_out, b_out, busy, done, pass, err_count, fail_vec
  );
endinterface

// File: rtl/de_morgan_checker.sv
// de_morgan_checker: applies all four a/b vectors to a NAND-style gate and records mismatches
module de_morgan_checker #(
  parameter int SETTLE = 1
) (
  input logic clk,
  input logic rst,
  de_morgan_checker_if.slave bus
);
  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CHECK, ST_DONE} state_t;
  state_t state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic a_out_q, a_out_d;
  logic b_out_q, b_out_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic pass_q, pass_d;
  logic [2:0] err_count_q, err_count_d;
  logic [3:0] fail_vec_q, fail_vec_d;
  logic mismatch;
  logic driving;
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    pass_d      = pass_q;
    err_count_d = err_count_q;
    fail_vec_d  = fail_vec_q;
    mismatch    = bus.c_in != ~(bus.a_out & bus.b_out);
    unique case (state_q)
      ST_IDLE: if (bus.start) begin
        state_d     = ST_SETTLE;
        idx_d       = 2'd0;
        cnt_d       = 4'd0;
        pass_d      = 1'b0;
        err_count_d = 3'd0;
        fail_vec_d  = 4'd0;
      end
      ST_SETTLE: begin
        cnt_d   = cnt_q + 4'd1;
        state_d = cnt_q == 4'(SETTLE - 1) ? ST_CHECK : ST_SETTLE;
      end
      ST_CHECK: begin
        if (mismatch) begin
          fail_vec_d[idx_q] = 1'b1;
          err_count_d       = err_count_q == 3'd4 ? err_count_q : err_count_q + 3'd1;
        end
        idx_d   = idx_q + 2'd1;
        cnt_d   = 4'd0;
        state_d = idx_q == 2'd3 ? ST_DONE : ST_SETTLE;
        pass_d  = idx_q == 2'd3 ? err_count_d == 3'd0 : pass_q;
      end
      ST_DONE: state_d = ST_IDLE;
    endcase
    driving = state_d == ST_SETTLE || state_d == ST_CHECK;
    a_out_d = driving & idx_d[1];
    b_out_d = driving & idx_d[0];
    busy_d  = driving;
    done_d  = state_d == ST_DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= 2'd0;
      cnt_q       <= 4'd0;
      a_out_q     <= 1'b0;
      b_out_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_count_q <= 3'd0;
      fail_vec_q  <= 4'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      a_out_q     <= a_out_d;
      b_out_q     <= b_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_count_q <= err_count_d;
      fail_vec_q  <= fail_vec_d;
    end
  end
  assign bus.a_out     = a_out_q;
  assign bus.b_out     = b_out_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.err_count = err_count_q;
  assign bus.fail_vec  = fail_vec_q;
endmodule

// File: tb/tb_de_morgan_checker.sv
// tb_de_morgan_checker: scoreboard bench running SETTLE=1 and SETTLE=3 checkers against modelled gates
module tb_de_morgan_checker;
  typedef struct packed {
    logic [31:0] done_edge;
    logic pass;
    logic [2:0] err;
    logic [3:0] fail;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  int gkind = 0;
  logic [3:0] gmask = 4'd0;
  int cyc = 0;
  int checks = 0;
  int passes = 0;
  exp_t sb[2][$];
  logic [1:0] trace[2][$];
  logic [11:0] outs[2];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic gate(input int k, input logic [3:0] m, input logic [1:0] v);
    return k == 0 ? ~(v[1] & v[0]) :
           k == 1 ? v[1] & v[0] :
           k == 2 ? 1'b1 :
           ~(v[1] & v[0]) ^ m[v];
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
  endtask
  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int S = 1 + 2 * g;
    de_morgan_checker_if bus ();
    de_morgan_checker #(.SETTLE(S)) dut (.clk(clk), .rst(rst), .bus(bus));
    assign bus.start = start;
    assign bus.c_in  = gate(gkind, gmask, {bus.a_out, bus.b_out});
    assign outs[g]   = {bus.a_out, bus.b_out, bus.busy, bus.done, bus.pass, bus.err_count, bus.fail_vec};
    always @(negedge clk) begin
      if (!rst && outs[g][9]) trace[g].push_back(outs[g][11:10]);
      if (!rst && outs[g][8]) begin
        chk($sformatf("inst%0d done_expected", g), 32'(sb[g].size() > 0), 1);
        if (sb[g].size() > 0) begin
          exp_t e;
          int ok;
          e = sb[g].pop_front();
          chk($sformatf("inst%0d done_edge", g), cyc, e.done_edge);
          chk($sformatf("inst%0d pass", g), 32'(outs[g][7]), 32'(e.pass));
          chk($sformatf("inst%0d err_count", g), 32'(outs[g][6:4]), 32'(e.err));
          chk($sformatf("inst%0d fail_vec", g), 32'(outs[g][3:0]), 32'(e.fail));
          chk($sformatf("inst%0d busy_in_done", g), 32'(outs[g][9]), 0);
          ok = trace[g].size() == 4 * (S + 1);
          for (int j = 0; j < trace[g].size(); j++) if (trace[g][j] != 2'(j / (S + 1))) ok = 0;
          chk($sformatf("inst%0d vector_trace", g), ok, 1);
        end
        trace[g].delete();
      end
    end
  end
  task automatic run(input int kind, input logic [3:0] mask, input logic [63:0] pat, input int n);
    int e0;
    int nf[2];
    logic [3:0] fv;
    int err;
    gkind = kind;
    gmask = mask;
    fv = 4'd0;
    err = 0;
    for (int v = 0; v < 4; v++) begin
      logic [1:0] vv;
      vv = 2'(v);
      fv[v] = gate(kind, mask, vv) != ~(vv[1] & vv[0]);
      err += int'(fv[v]);
    end
    e0 = cyc + 1;
    for (int i = 0; i < 2; i++) begin
      nf[i] = e0;
      for (int k = 0; k < n; k++) begin
        if (pat[k] && e0 + k >= nf[i]) begin
          sb[i].push_back({32'(e0 + k + 4 * (2 + 2 * i)), err == 0, 3'(err), fv});
          nf[i] = e0 + k + 4 * (2 + 2 * i) + 2;
        end
      end
    end
    for (int k = 0; k < n; k++) begin
      start = pat[k];
      @(negedge clk);
    end
    start = 1'b0;
    for (int i = 0; i < 400 && sb[0].size() + sb[1].size() > 0; i++) @(negedge clk);
    chk("scoreboard_drained", sb[0].size() + sb[1].size(), 0);
    sb[0].delete();
    sb[1].delete();
    repeat (2) @(negedge clk);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) chk($sformatf("inst%0d outs_in_reset", i), 32'(outs[i]), 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 2; i++) chk($sformatf("inst%0d idle_without_start", i), 32'(outs[i]), 0);
    run(0, 4'd0, 64'b1, 1);
    run(1, 4'd0, 64'b1, 1);
    run(2, 4'd0, 64'b1, 1);
    run(0, 4'd0, 64'b101, 3);
    run(1, 4'd0, {64{1'b1}}, 19);
    gkind = 3;
    gmask = 4'b0001;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("inst0 mid_check_vector", 32'(outs[0][11:10]), 2);
    chk("inst0 mid_check_err", 32'(outs[0][6:4]), 1);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) chk($sformatf("inst%0d outs_after_abort", i), 32'(outs[i]), 0);
    rst = 1'b0;
    trace[0].delete();
    trace[1].delete();
    @(negedge clk);
    run(3, 4'b0001, 64'b1, 1);
    for (int r = 0; r < 8; r++) run(int'($urandom_range(0, 3)), 4'($urandom), 64'b1, 1);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
